uart_tx_arbiter: RTL

- Shares one UART transmitter (byte-in, serial-out, busy flag) between N_REQ byte producers, e.g. command responder, debug logger, status reporter.
- Round-robin arbitration at packet granularity. A winner keeps the transmitter until its byte flagged last has been sent, or until it goes idle past a timeout.
- Sits between the requesters and the transmitter; it issues start pulses and tracks the busy flag.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rr_pick.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit arbiter slice.
// State encodings and transmitter handshake limits.
package uart_pkg;

   localparam int UART_BYTE_W   = 8;
   localparam int BUSY_SEEN_MAX = 4;
   localparam int BUSY_CNT_W    = $clog2(BUSY_SEEN_MAX);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] ISSUE     = 3'd1;
   localparam logic [2:0] WAIT_BUSY = 3'd2;
   localparam logic [2:0] WAIT_DONE = 3'd3;
   localparam logic [2:0] HOLD      = 3'd4;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker.
// Searches upward from rr_last+1 with wrap.
module uart_rr_pick #(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  rr_last,
   output logic [N_REQ-1:0] win_oh,
   output logic [ID_W-1:0]  win_id,
   output logic             any_req
);

   logic            found;
   logic [ID_W-1:0] idx;

   assign any_req = |req;

   always_comb begin
      win_oh = '0;
      win_id = '0;
      found  = 1'b0;
      idx    = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = ID_W'((int'(rr_last) + k) % N_REQ);
         if (!found && req[idx]) begin
            found       = 1'b1;
            win_oh[idx] = 1'b1;
            win_id      = idx;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART transmitter.
// An owner keeps the grant until its last byte or a hold timeout.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ        = 4,
   parameter int HOLD_TIMEOUT = 1024,
   parameter int ID_W         = $clog2(N_REQ)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [N_REQ-1:0]             req_valid,
   input  logic [UART_BYTE_W*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]             req_last,
   output logic [N_REQ-1:0]             req_ready,
   output logic                         tx_start,
   output logic [UART_BYTE_W-1:0]       tx_data,
   input  logic                         tx_busy,
   output logic [N_REQ-1:0]             grant,
   output logic [ID_W-1:0]              grant_id,
   output logic                         timeout_err
);

   localparam int HC_W = $clog2(HOLD_TIMEOUT);

   logic [2:0]             state;
   logic [ID_W-1:0]        rr_last;
   logic                   last_q;
   logic [HC_W-1:0]        hold_cnt;
   logic [BUSY_CNT_W-1:0]  wait_cnt;
   logic [N_REQ-1:0]       win_oh;
   logic [ID_W-1:0]        win_id;
   logic                   any_req;
   logic                   byte_done;
   logic                   own_valid;
   logic [UART_BYTE_W-1:0] req_bytes [N_REQ];

   for (genvar i = 0; i < N_REQ; i++) begin : g_bytes
      assign req_bytes[i] = req_data[UART_BYTE_W*i +: UART_BYTE_W];
   end

   uart_rr_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_pick (
      .req     (req_valid),
      .rr_last (rr_last),
      .win_oh  (win_oh),
      .win_id  (win_id),
      .any_req (any_req)
   );

   assign own_valid = |(req_valid & grant);

   // A missing busy response is treated as a completed byte.
   assign byte_done = !tx_busy &&
      ((state == WAIT_DONE) ||
       (state == WAIT_BUSY &&
        wait_cnt == BUSY_CNT_W'(BUSY_SEEN_MAX - 1)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         rr_last     <= ID_W'(N_REQ - 1);
         grant       <= '0;
         grant_id    <= '0;
         tx_data     <= '0;
         tx_start    <= 1'b0;
         req_ready   <= '0;
         timeout_err <= 1'b0;
         last_q      <= 1'b0;
         hold_cnt    <= '0;
         wait_cnt    <= '0;
      end else begin
         tx_start    <= 1'b0;
         req_ready   <= '0;
         timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req && !tx_busy) begin
                  grant     <= win_oh;
                  grant_id  <= win_id;
                  tx_data   <= req_bytes[win_id];
                  last_q    <= req_last[win_id];
                  tx_start  <= 1'b1;
                  req_ready <= win_oh;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               wait_cnt <= '0;
               state    <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (tx_busy) state <= WAIT_DONE;
               else wait_cnt <= wait_cnt + 1'b1;
            end
            WAIT_DONE: ;
            HOLD: begin
               if (own_valid && !tx_busy) begin
                  tx_data   <= req_bytes[grant_id];
                  last_q    <= req_last[grant_id];
                  tx_start  <= 1'b1;
                  req_ready <= grant;
                  hold_cnt  <= '0;
                  state     <= ISSUE;
               end else if (hold_cnt == HC_W'(HOLD_TIMEOUT - 1)) begin
                  timeout_err <= 1'b1;
                  grant       <= '0;
                  rr_last     <= grant_id;
                  state       <= IDLE;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: begin
               grant <= '0;
               state <= IDLE;
            end
         endcase
         if (byte_done) begin
            if (last_q) begin
               grant   <= '0;
               rr_last <= grant_id;
               state   <= IDLE;
            end else begin
               hold_cnt <= '0;
               state    <= HOLD;
            end
         end
      end
   end

endmodule
